// File: rtl/ex_tracker_q_pkg.sv
// Shared trace record types and the EX tracker state encoding.
package ex_tracker_q_pkg;

   localparam int unsigned TS_FIELD_W   = 32;
   localparam int unsigned ADDR_FIELD_W = 32;

   typedef struct packed {
      logic [TS_FIELD_W-1:0] time_start;
      logic [TS_FIELD_W-1:0] time_end;
   } trace_span;

   typedef struct packed {
      logic [TS_FIELD_W-1:0]   time_start;
      logic [TS_FIELD_W-1:0]   time_end;
      trace_span               mem_access_req;
      trace_span               mem_access_res;
      logic [ADDR_FIELD_W-1:0] mem_addr;
      logic                    mem_we;
   } ex_data_t;

   typedef struct packed {
      logic        pass_through;
      logic [31:0] pc;
      logic [31:0] instr;
      trace_span   id_data;
      ex_data_t    ex_data;
   } trace_output;

   typedef enum logic [1:0] {
      IDLE,
      EX_ACTIVE,
      WAIT_GNT,
      WAIT_RVALID
   } ex_tracker_state;

endpackage

// File: rtl/ex_tracker_q_fifo.sv
// DEPTH-entry synchronous FIFO of trace_output; a push into a full FIFO is
// accepted only when a pop happens at the same edge.
module trace_fifo
   import ex_tracker_q_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  trace_output            din,
   input  logic                   pop,
   output trace_output            head_c,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full_c,
   output logic                   empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   trace_output     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty_c = (count == CW'(0));
   assign full_c  = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty_c;
   assign do_push = push && (!full_c || do_pop);
   assign head_c  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   // Storage needs no reset: pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ex_tracker_q.sv
// EX-stage trace tracker: queues ID elements, times the EX phase and the
// data-memory handshake of each, and emits the enriched record.
module ex_tracker_q
   import ex_tracker_q_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned TS_WIDTH     = 32,
   parameter int unsigned DEPTH        = 4,
   parameter bit          TRACK_RVALID = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [TS_WIDTH-1:0]    counter,
   input  logic                   id_data_ready,
   input  trace_output            id_data_i,
   input  logic                   ex_ready,
   input  logic                   data_req_i,
   input  logic [ADDR_WIDTH-1:0]  data_addr_i,
   input  logic                   data_we_i,
   input  logic                   data_gnt_i,
   input  logic                   data_rvalid_i,
   output trace_output            ex_data_o,
   output logic                   ex_data_ready,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow_o
);

   ex_tracker_state        state;
   trace_output            work;
   logic                   first;

   trace_output            head_c;
   logic                   full_c;
   logic                   empty_c;
   logic                   pop_c;

   logic [TS_FIELD_W-1:0]  ts_c;
   trace_output            work_upd_c;
   logic                   grant_c;
   logic                   done_c;
   logic                   to_gnt_c;
   logic                   to_rvalid_c;

   assign pop_c = (state == IDLE) && !empty_c;
   assign ts_c  = TS_FIELD_W'(counter);

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (id_data_ready),
      .din     (id_data_i),
      .pop     (pop_c),
      .head_c  (head_c),
      .count   (fifo_count),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

   // Working-element update and phase events for the current cycle.
   always_comb begin
      work_upd_c  = work;
      grant_c     = 1'b0;
      done_c      = 1'b0;
      to_gnt_c    = 1'b0;
      to_rvalid_c = 1'b0;

      if ((state == EX_ACTIVE) && first) work_upd_c.ex_data.time_start = ts_c;

      case (state)
         EX_ACTIVE: begin
            if (data_req_i) begin
               work_upd_c.ex_data.mem_access_req.time_start = ts_c;
               work_upd_c.ex_data.mem_addr = ADDR_FIELD_W'(data_addr_i);
               work_upd_c.ex_data.mem_we   = data_we_i;
               if (data_gnt_i) grant_c  = 1'b1;
               else            to_gnt_c = 1'b1;
            end else if (ex_ready) begin
               work_upd_c.ex_data.time_end = ts_c;
               done_c = 1'b1;
            end
         end
         WAIT_GNT: begin
            if (data_gnt_i) grant_c = 1'b1;
         end
         WAIT_RVALID: begin
            if (data_rvalid_i) begin
               work_upd_c.ex_data.mem_access_res.time_end = ts_c;
               work_upd_c.ex_data.time_end = ts_c;
               done_c = 1'b1;
            end
         end
         default: ;
      endcase

      // Grant either ends the element or opens the response phase.
      if (grant_c) begin
         work_upd_c.ex_data.mem_access_req.time_end = ts_c;
         if (TRACK_RVALID) begin
            work_upd_c.ex_data.mem_access_res.time_start = ts_c;
            to_rvalid_c = 1'b1;
         end else begin
            work_upd_c.ex_data.time_end = ts_c;
            done_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         work          <= '0;
         first         <= 1'b0;
         ex_data_o     <= '0;
         ex_data_ready <= 1'b0;
         overflow_o    <= 1'b0;
      end else begin
         ex_data_ready <= 1'b0;
         if (id_data_ready && full_c && !pop_c) overflow_o <= 1'b1;

         case (state)
            IDLE: begin
               if (!empty_c) begin
                  if (head_c.pass_through) begin
                     ex_data_o     <= head_c;
                     ex_data_ready <= 1'b1;
                  end else begin
                     work  <= head_c;
                     first <= 1'b1;
                     state <= EX_ACTIVE;
                  end
               end
            end
            default: begin
               work  <= work_upd_c;
               first <= 1'b0;
               if (done_c) begin
                  ex_data_o     <= work_upd_c;
                  ex_data_ready <= 1'b1;
                  state         <= IDLE;
               end else if (to_rvalid_c) begin
                  state <= WAIT_RVALID;
               end else if (to_gnt_c) begin
                  state <= WAIT_GNT;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_tracker_q.sv
// Scoreboard bench: two trackers (response-tracking and grant-only) share
// one directed stimulus stream; each has its own expected-emit queue.
module tb_ex_tracker_q;
   import ex_tracker_q_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cyc = 32'd0;

   logic        id_data_ready;
   trace_output id_data;
   logic        ex_ready;
   logic        data_req;
   logic [31:0] data_addr;
   logic        data_we;
   logic        data_gnt;
   logic        data_rvalid;

   trace_output out1, out0;
   logic        rdy1, rdy0;
   logic [2:0]  cnt1, cnt0;
   logic        ovf1, ovf0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      trace_output d;
      int unsigned cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q0[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   ex_tracker_q #(.ADDR_WIDTH(32), .TS_WIDTH(32), .DEPTH(4), .TRACK_RVALID(1'b1)) u_rv (
      .clk(clk), .rst(rst), .counter(cyc), .id_data_ready(id_data_ready), .id_data_i(id_data),
      .ex_ready(ex_ready), .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
      .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .ex_data_o(out1), .ex_data_ready(rdy1),
      .fifo_count(cnt1), .overflow_o(ovf1));

   ex_tracker_q #(.ADDR_WIDTH(32), .TS_WIDTH(16), .DEPTH(4), .TRACK_RVALID(1'b0)) u_gnt (
      .clk(clk), .rst(rst), .counter(cyc[15:0]), .id_data_ready(id_data_ready), .id_data_i(id_data),
      .ex_ready(ex_ready), .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
      .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .ex_data_o(out0), .ex_data_ready(rdy0),
      .fifo_count(cnt0), .overflow_o(ovf0));

   function automatic trace_output mk(input logic pt, input logic [31:0] pc);
      trace_output t;
      t = '0;
      t.pass_through = pt;
      t.pc = pc;
      t.instr = pc ^ 32'h1300_0013;
      t.id_data.time_start = pc + 32'd1;
      t.id_data.time_end = pc + 32'd2;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %h expected %h", nm, cyc, got, exp);
      end
   endtask

   task automatic cmp_emit(input string nm, input trace_output got, input exp_t e);
      total++;
      if (got !== e.d || cyc != e.cyc) begin
         bad++;
         $display("FAIL %s pc=%h: cyc %0d expected cyc %0d; got %h expected %h",
                  nm, e.d.pc, cyc, e.cyc, got, e.d);
      end
   endtask

   always @(negedge clk) begin
      if (rdy1 === 1'b1) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL emit_rv unexpected at cyc %0d got pc=%h", cyc, out1.pc);
         end else cmp_emit("emit_rv", out1, q1.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rdy0 === 1'b1) begin
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL emit_gnt unexpected at cyc %0d got pc=%h", cyc, out0.pc);
         end else cmp_emit("emit_gnt", out0, q0.pop_front());
      end
   end

   // Advance to cycle n; pulses last exactly one cycle.
   task automatic at(input int unsigned n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
         id_data_ready = 1'b0;
         ex_ready      = 1'b0;
         data_req      = 1'b0;
         data_gnt      = 1'b0;
         data_rvalid   = 1'b0;
         rst           = 1'b1;
      end
   endtask

   task automatic push(input trace_output t);
      id_data_ready = 1'b1;
      id_data       = t;
   endtask

   task automatic exp_both(input trace_output d, input int unsigned c1, input int unsigned c0);
      q1.push_back('{d: d, cyc: c1});
      q0.push_back('{d: d, cyc: c0});
   endtask

   task automatic chk_idle_regs(input string tag, input logic [2:0] cnt_exp, input logic ovf_exp);
      chk({tag, "_rdy_rv"}, 32'(rdy1), 32'd0);
      chk({tag, "_rdy_gnt"}, 32'(rdy0), 32'd0);
      chk({tag, "_cnt_rv"}, 32'(cnt1), 32'(cnt_exp));
      chk({tag, "_cnt_gnt"}, 32'(cnt0), 32'(cnt_exp));
      chk({tag, "_ovf_rv"}, 32'(ovf1), 32'(ovf_exp));
      chk({tag, "_ovf_gnt"}, 32'(ovf0), 32'(ovf_exp));
   endtask

   trace_output e;

   initial begin
      rst = 1'b0;
      id_data_ready = 1'b0; id_data = '0; ex_ready = 1'b0;
      data_req = 1'b0; data_addr = '0; data_we = 1'b0;
      data_gnt = 1'b0; data_rvalid = 1'b0;

      at(4);
      chk_idle_regs("reset", 3'd0, 1'b0);
      chk("reset_out_rv", 32'(out1 != '0), 32'd0);
      chk("reset_out_gnt", 32'(out0 != '0), 32'd0);

      // Pass-through stream
      at(10); push(mk(1'b1, 32'h10)); exp_both(mk(1'b1, 32'h10), 12, 12);
      at(11); push(mk(1'b1, 32'h11)); exp_both(mk(1'b1, 32'h11), 13, 13);
      at(12); push(mk(1'b1, 32'h12)); exp_both(mk(1'b1, 32'h12), 14, 14);
      chk("pt_cnt_rv", 32'(cnt1), 32'd1);
      chk("pt_ovf_rv", 32'(ovf1), 32'd0);

      // ALU element
      at(20); push(mk(1'b0, 32'h20));
      e = mk(1'b0, 32'h20);
      e.ex_data.time_start = 32'd22; e.ex_data.time_end = 32'd25;
      exp_both(e, 26, 26);
      at(25); ex_ready = 1'b1;

      // Load; stray rvalid/ex_ready while waiting for grant are ignored
      at(30); push(mk(1'b0, 32'h30));
      e = mk(1'b0, 32'h30);
      e.ex_data.time_start = 32'd32;
      e.ex_data.mem_access_req = '{time_start: 32'd34, time_end: 32'd36};
      e.ex_data.mem_addr = 32'h1000;
      e.ex_data.time_end = 32'd36;
      q0.push_back('{d: e, cyc: 37});
      e.ex_data.mem_access_res = '{time_start: 32'd36, time_end: 32'd39};
      e.ex_data.time_end = 32'd39;
      q1.push_back('{d: e, cyc: 40});
      at(34); data_req = 1'b1; data_addr = 32'h1000; data_we = 1'b0;
      at(35); data_rvalid = 1'b1; ex_ready = 1'b1;
      at(36); data_gnt = 1'b1;
      at(39); data_rvalid = 1'b1;

      // Handshake noise while idle
      at(45); data_gnt = 1'b1; data_rvalid = 1'b1;

      // Store with grant at the request edge
      at(50); push(mk(1'b0, 32'h50));
      e = mk(1'b0, 32'h50);
      e.ex_data.time_start = 32'd52;
      e.ex_data.mem_access_req = '{time_start: 32'd54, time_end: 32'd54};
      e.ex_data.mem_addr = 32'h2004; e.ex_data.mem_we = 1'b1;
      e.ex_data.time_end = 32'd54;
      q0.push_back('{d: e, cyc: 55});
      e.ex_data.mem_access_res = '{time_start: 32'd54, time_end: 32'd57};
      e.ex_data.time_end = 32'd57;
      q1.push_back('{d: e, cyc: 58});
      at(54); data_req = 1'b1; data_gnt = 1'b1; data_addr = 32'h2004; data_we = 1'b1;
      at(57); data_rvalid = 1'b1;

      // Overflow while held in WAIT_GNT
      at(70); push(mk(1'b0, 32'h70));
      e = mk(1'b0, 32'h70);
      e.ex_data.time_start = 32'd72;
      e.ex_data.mem_access_req = '{time_start: 32'd73, time_end: 32'd83};
      e.ex_data.mem_addr = 32'h3000;
      e.ex_data.time_end = 32'd83;
      q0.push_back('{d: e, cyc: 84});
      e.ex_data.mem_access_res = '{time_start: 32'd83, time_end: 32'd86};
      e.ex_data.time_end = 32'd86;
      q1.push_back('{d: e, cyc: 87});
      at(73); data_req = 1'b1; data_addr = 32'h3000; data_we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         at(75 + i);
         push(mk(1'b1, 32'h81 + 32'(i)));
         if (i < 4) exp_both(mk(1'b1, 32'h81 + 32'(i)), 88 + i, 85 + i);
      end
      at(82);
      chk_idle_regs("ovf", 3'd4, 1'b1);
      at(83); data_gnt = 1'b1;
      at(86); data_rvalid = 1'b1;
      at(95);
      chk("ovf_sticky_rv", 32'(ovf1), 32'd1);
      chk("ovf_sticky_gnt", 32'(ovf0), 32'd1);

      // Reset while the response-tracking instance sits in WAIT_RVALID
      at(100); push(mk(1'b0, 32'hA0));
      e = mk(1'b0, 32'hA0);
      e.ex_data.time_start = 32'd102;
      e.ex_data.mem_access_req = '{time_start: 32'd103, time_end: 32'd105};
      e.ex_data.mem_addr = 32'h4000; e.ex_data.mem_we = 1'b1;
      e.ex_data.time_end = 32'd105;
      q0.push_back('{d: e, cyc: 106});
      at(103); data_req = 1'b1; data_addr = 32'h4000; data_we = 1'b1;
      at(105); data_gnt = 1'b1;
      at(106); push(mk(1'b1, 32'hA1));
      at(107); rst = 1'b0;
      at(108);
      chk_idle_regs("midrst", 3'd0, 1'b0);
      chk("midrst_out_rv", 32'(out1 != '0), 32'd0);
      at(110); data_rvalid = 1'b1;
      at(112); ex_ready = 1'b1;

      at(120);
      chk("drain_rv", 32'(q1.size()), 32'd0);
      chk("drain_gnt", 32'(q0.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
